fifo_serial_tx: RTL and testbench

FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

---
 rtl/fifo_serial_tx.sv | 105 ++++++++++
 tb/tb_fifo_serial_tx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_serial_tx.sv
// Serial transmitter draining a FIFO read port: one Read_enable per byte, then a
// start bit, DATA_WIDTH data bits LSB-first, optional even parity and a stop bit.
module fifo_serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic                  clk_read,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  Read_enable,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
    } state_t;

    state_t                state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [BIT_W-1:0]      bit_idx, bit_idx_d;
    logic [DATA_WIDTH-1:0] shreg, shreg_d;
    logic                  parity, parity_d;
    logic                  tx_d;
    logic                  bit_end;

    assign bit_end     = (cnt == CNT_LAST);
    assign Read_enable = (state == FETCH);
    assign busy        = (state != IDLE);
    assign frame_done  = (state == STOP) && bit_end;

    always_ff @(posedge clk_read) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            parity  <= 1'b0;
            tx      <= 1'b1;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
            shreg   <= shreg_d;
            parity  <= parity_d;
            tx      <= tx_d;
        end
    end

    always_comb begin
        state_d   = state;
        bit_idx_d = bit_idx;
        shreg_d   = shreg;
        parity_d  = parity;
        cnt_d     = '0;
        tx_d      = 1'b1;

        case (state)
            IDLE:   if (!fifo_empty) state_d = FETCH;
            FETCH:  state_d = LOAD;
            LOAD: begin
                shreg_d   = fifo_data;
                parity_d  = ^fifo_data;
                bit_idx_d = '0;
                state_d   = START;
            end
            START:  if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == BIT_LAST) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx + 1'b1;
                        shreg_d   = shreg >> 1;
                    end
                end
            end
            PARITY: if (bit_end) state_d = STOP;
            STOP:   if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Baud counter restarts on every state entry and on every bit boundary.
        if (state_d == state && !bit_end &&
            (state == START || state == DATA || state == PARITY || state == STOP))
            cnt_d = cnt + 1'b1;

        // tx is registered, so it is driven from the value the next state will present.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx: a default instance and a parity-enabled
// instance share clock and reset; expected frames are hand-written slot patterns.
module tb_fifo_serial_tx;

    logic       clk_read = 1'b0;
    logic       rst;
    logic       empty_a, empty_p;
    logic [7:0] data_a, data_p;
    logic       re_a, tx_a, busy_a, fd_a;
    logic       re_p, tx_p, busy_p, fd_p;
    bit         sel;
    int         n_cmp = 0;
    int         n_err = 0;
    int         re_cnt_a = 0, re_cnt_p = 0, fd_cnt_a = 0, fd_cnt_p = 0;

    always #5 clk_read = ~clk_read;

    fifo_serial_tx dut_a (
        .clk_read(clk_read), .rst(rst), .fifo_empty(empty_a), .fifo_data(data_a),
        .Read_enable(re_a), .tx(tx_a), .busy(busy_a), .frame_done(fd_a)
    );

    fifo_serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_p (
        .clk_read(clk_read), .rst(rst), .fifo_empty(empty_p), .fifo_data(data_p),
        .Read_enable(re_p), .tx(tx_p), .busy(busy_p), .frame_done(fd_p)
    );

    always @(posedge clk_read) begin
        if (re_a) re_cnt_a <= re_cnt_a + 1;
        if (re_p) re_cnt_p <= re_cnt_p + 1;
        if (fd_a) fd_cnt_a <= fd_cnt_a + 1;
        if (fd_p) fd_cnt_p <= fd_cnt_p + 1;
    end

    wire tx_m   = sel ? tx_p   : tx_a;
    wire re_m   = sel ? re_p   : re_a;
    wire busy_m = sel ? busy_p : busy_a;
    wire fd_m   = sel ? fd_p   : fd_a;

    task automatic tick();
        @(posedge clk_read);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input logic e, input logic [7:0] d);
        if (s) begin
            empty_p = e;
            data_p  = d;
        end else begin
            empty_a = e;
            data_a  = d;
        end
    endtask

    // slots: bit k is the tx level of bit period k (start, data LSB-first, [parity], stop)
    task automatic send(input bit s, input logic [7:0] d, input logic [10:0] slots,
                        input int nslots, input string tag);
        logic [43:0] obs_tx, obs_fd, exp_tx, exp_fd;
        int re0, fd0, ns;
        sel    = s;
        ns     = nslots * 4;
        re0    = s ? re_cnt_p : re_cnt_a;
        fd0    = s ? fd_cnt_p : fd_cnt_a;
        obs_tx = '0; obs_fd = '0; exp_tx = '0; exp_fd = '0;
        drive(s, 1'b0, d);
        tick();
        chk({tag, "_fetch_re"}, 64'(re_m), 64'd1);
        chk({tag, "_fetch_tx"}, 64'(tx_m), 64'd1);
        drive(s, 1'b1, d);            // FIFO drained by the read; data_out still valid
        tick();
        chk({tag, "_load_re"}, 64'(re_m), 64'd0);
        chk({tag, "_load_tx"}, 64'(tx_m), 64'd1);
        tick();
        drive(s, 1'b1, ~d);           // must not disturb the frame in flight
        for (int k = 0; k < ns; k++) begin
            obs_tx[k] = tx_m;
            obs_fd[k] = fd_m;
            exp_tx[k] = slots[k / 4];
            tick();
        end
        exp_fd[ns - 1] = 1'b1;
        chk({tag, "_tx_frame"}, 64'(obs_tx), 64'(exp_tx));
        chk({tag, "_frame_done"}, 64'(obs_fd), 64'(exp_fd));
        chk({tag, "_re_pulses"}, 64'((s ? re_cnt_p : re_cnt_a) - re0), 64'd1);
        chk({tag, "_fd_pulses"}, 64'((s ? fd_cnt_p : fd_cnt_a) - fd0), 64'd1);
        chk({tag, "_idle_busy"}, 64'(busy_m), 64'd0);
        chk({tag, "_idle_tx"}, 64'(tx_m), 64'd1);
    endtask

    initial begin
        logic [82:0] b2b_obs, b2b_exp;
        logic [9:0]  s1, s2;
        logic        any_re, any_low, any_busy;
        int          re0, fd0;

        rst = 1'b1;
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'h00);
        tick();
        tick();
        chk("rst_tx",   64'(tx_a),   64'd1);
        chk("rst_re",   64'(re_a),   64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_fd",   64'(fd_a),   64'd0);
        chk("rst_p_tx", 64'(tx_p),   64'd1);
        rst = 1'b0;
        tick();

        // single byte 0xA5: 0,1,0,1,0,0,1,0,1,1
        send(1'b0, 8'hA5, 11'h34A, 10, "a5");

        // parity instance: 0x07 -> parity 1, 0x03 -> parity 0
        send(1'b1, 8'h07, 11'h60E, 11, "p07");
        send(1'b1, 8'h03, 11'h406, 11, "p03");

        // empty FIFO for 100 cycles
        sel = 1'b0;
        any_re = 1'b0; any_low = 1'b0; any_busy = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            any_re   |= re_a;
            any_low  |= ~tx_a;
            any_busy |= busy_a;
        end
        chk("empty_quiet", 64'({any_re, any_low, any_busy}), 64'd0);

        // back-to-back 0x01 then 0x80 with fifo_empty held low
        s1 = 10'h202;
        s2 = 10'h300;
        re0 = re_cnt_a;
        drive(1'b0, 1'b0, 8'h01);
        tick();
        tick();
        tick();
        drive(1'b0, 1'b0, 8'h80);
        for (int k = 0; k < 83; k++) begin
            b2b_obs[k] = tx_a;
            if (k < 40)      b2b_exp[k] = s1[k / 4];
            else if (k < 43) b2b_exp[k] = 1'b1;
            else             b2b_exp[k] = s2[(k - 43) / 4];
            if (k == 42) drive(1'b0, 1'b1, 8'h80);
            tick();
        end
        chk("b2b_tx", 64'(b2b_obs[63:0]), 64'(b2b_exp[63:0]));
        chk("b2b_tx_hi", 64'(b2b_obs[82:64]), 64'(b2b_exp[82:64]));
        chk("b2b_re_pulses", 64'(re_cnt_a - re0), 64'd2);
        chk("b2b_idle", 64'(busy_a), 64'd0);

        // reset during data bit 3 of 0x55
        fd0 = fd_cnt_a;
        drive(1'b0, 1'b0, 8'h55);
        tick();
        drive(1'b0, 1'b1, 8'h55);
        tick();
        tick();
        for (int k = 0; k < 17; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_tx",   64'(tx_a),   64'd1);
        chk("midrst_busy", 64'(busy_a), 64'd0);
        re0 = re_cnt_a;
        for (int k = 0; k < 10; k++) tick();
        chk("midrst_no_resend", 64'(re_cnt_a - re0), 64'd0);
        chk("midrst_no_fd",     64'(fd_cnt_a - fd0), 64'd0);
        send(1'b0, 8'hC3, 11'h386, 10, "c3");

        // fifo_empty rises during FETCH (done inside send); then stays idle
        send(1'b0, 8'h3C, 11'h278, 10, "late_empty");
        any_busy = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            any_busy |= busy_a | re_a;
        end
        chk("late_empty_stays_idle", 64'(any_busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
